imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous word RAM between the CPU instruction-fetch port (read-only) and the load/store port (read/write).
- Sits between the CPU core and the RAM instance.
- Arbitrates, sequences each access through a fixed 2-cycle ACCESS/RESP pipeline, and returns read data with a one-cycle ack pulse.
- The data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 10, word-address width into the RAM.
- DATA_W, 32, data width; must be a multiple of 8.
- STARVE_MAX, 4, consecutive lost contended decisions after which fetch wins the next contended decision; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  ADDR_W  fetch word address.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables for writes.
- d_ack  out  1  one-cycle pulse; d_rdata valid this cycle (reads) or write committed.
- d_rdata  out  DATA_W  load read data.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_be  out  DATA_W/8  RAM byte enables.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Clocking and reset: one clock domain. clr is sampled on the rising clk edge.
- Reset values:
  - State = IDLE; gnt = none; starve_cnt = 0.
  - All outputs 0: acks, busy, ram_en, ram_we, ram_be.
  - i_rdata and d_rdata = 0.
- Output gating: ram_en and ram_we are gated by ~clr, so no RAM write occurs in any cycle where clr = 1.
- States:
  - IDLE: no access in progress.
  - ACCESS: combinational, from registered gnt:
    - ram_en = 1.
    - ram_addr is muxed from the granted port.
    - For gnt = D: ram_we = d_we, ram_be = d_be, ram_wdata = d_wdata.
    - For gnt = I: ram_we = 0, ram_be = 0.
  - RESP:
    - The granted port's ack = 1.
    - Its rdata = ram_rdata, registered in the rdata output register.
    - rdata holds until the next RESP for that port.
    - For a write, d_rdata is unchanged.
- Transitions (at the rising edge):
  - IDLE -> ACCESS when any req = 1; gnt latched per the arbitration rule.
  - ACCESS -> RESP always.
  - RESP -> ACCESS if the non-granted port's req = 1; that port is granted.
  - RESP -> IDLE otherwise.
  - The just-acked port's req is ignored at the RESP edge, so a requester holding req through its ack cycle gets no duplicate access.
- Latency and throughput:
  - req first high at edge N in IDLE -> ACCESS in cycle N+1 -> ack in cycle N+2.
  - Back-to-back alternating accesses: one per 2 cycles.
  - A single port re-requesting after IDLE: one access per 3 cycles.
- Arbitration (fixed priority):
  - Only one req: that port wins.
  - Both req (contended decision): D wins unless starve_cnt == STARVE_MAX, in which case I wins.
  - starve_cnt increments, saturating, when I loses a contended decision.
  - starve_cnt clears when I is granted.
- Reset mid-operation (clr in ACCESS or RESP):
  - Next state = IDLE.
  - No ack is issued for the in-flight access.
  - No RAM write is performed.
  - Requesters must re-issue.
- Simultaneous clr and req: clr wins.
- Address wrap: none; addresses pass through unchanged.

Optional Feature:
- Macro: IMEM_DMEM_ARB_RR_EN.
- Defined:
  - Contended decisions alternate: the port that was NOT granted last wins.
  - A last-granted register resets to I, so D wins the first contention after reset.
  - starve_cnt and STARVE_MAX logic are not compiled.
- Undefined: the fixed-priority-with-starvation rule above applies.

Test Plan:
- Reset, then i_req=1 with i_addr=0x004 and RAM[4]=0x00500093:
  - ram_en=1, ram_addr=0x004 in the cycle after the request edge.
  - i_ack=1 and i_rdata=0x00500093 the following cycle.
  - busy low afterwards.
- d_req write, d_addr=0x010, d_wdata=0xDEADBEEF, d_be=4'b0011, RAM[0x10]=0x11223344:
  - d_ack pulses once.
  - A subsequent read of 0x010 returns 0x1122BEEF.
- Both req asserted in IDLE and held (requesters re-assert immediately after each ack):
  - Grant order is D, then I, then D, I alternating (RESP->ACCESS handoff).
  - Acks are 2 cycles apart; no duplicate acks.
- Starvation: STARVE_MAX=2, with d_req re-presented in IDLE together with i_req each time:
  - I wins the 3rd contended decision.
  - starve_cnt returns to 0.
- clr=1 during the ACCESS cycle of a D write to 0x020:
  - RAM[0x20] unchanged.
  - No d_ack.
  - State IDLE and all outputs 0 on the next cycle.
- With IMEM_DMEM_ARB_RR_EN defined, both ports continuously requesting from reset:
  - Grants are D, I, D, I.
  - No port is granted twice in a row under contention.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch port and a load/store port.
// Define IMEM_DMEM_ARB_RR_EN to replace fixed-priority-with-starvation by round-robin on contention.
module imem_dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} gnt_t;

    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              contend_pick_i;
    logic              new_grant;
    logic              in_access;
    logic              in_resp;
    logic              gnt_is_d;

`ifdef IMEM_DMEM_ARB_RR_EN
    gnt_t last_q, last_d;
    assign contend_pick_i = (last_q == GNT_D);
`else
    logic [3:0] starve_cnt_q, starve_cnt_d;
    assign contend_pick_i = (starve_cnt_q == 4'(STARVE_MAX));
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    state_d = ST_ACCESS;
                    gnt_d   = contend_pick_i ? GNT_I : GNT_D;
                end else if (i_req) begin
                    state_d = ST_ACCESS;
                    gnt_d   = GNT_I;
                end else if (d_req) begin
                    state_d = ST_ACCESS;
                    gnt_d   = GNT_D;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (gnt_q == GNT_I) begin
                    i_rdata_d = ram_rdata;
                end else if (gnt_q == GNT_D && !d_we) begin
                    d_rdata_d = ram_rdata;
                end
                // The just-acked port's req is ignored here; only the other side may take over.
                if (gnt_q == GNT_I && d_req) begin
                    state_d = ST_ACCESS;
                    gnt_d   = GNT_D;
                end else if (gnt_q == GNT_D && i_req) begin
                    state_d = ST_ACCESS;
                    gnt_d   = GNT_I;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    assign new_grant = (state_d == ST_ACCESS) && (state_q != ST_ACCESS);

`ifdef IMEM_DMEM_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (new_grant) begin
            last_d = gnt_d;
        end
    end
`else
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (new_grant && gnt_d == GNT_I) begin
            starve_cnt_d = 4'd0;
        end else if (state_q == ST_IDLE && i_req && d_req && !contend_pick_i) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            gnt_q     <= GNT_NONE;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef IMEM_DMEM_ARB_RR_EN
            last_q    <= GNT_I;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef IMEM_DMEM_ARB_RR_EN
            last_q    <= last_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Strobes and acks are masked by clr so a reset cycle never writes RAM or acks.
    assign in_access = (state_q == ST_ACCESS) && !clr;
    assign in_resp   = (state_q == ST_RESP) && !clr;
    assign gnt_is_d  = (gnt_q == GNT_D);

    assign ram_en    = in_access;
    assign ram_we    = in_access && gnt_is_d && d_we;
    assign ram_be    = (in_access && gnt_is_d) ? d_be : '0;
    assign ram_addr  = in_access ? (gnt_is_d ? d_addr : i_addr) : '0;
    assign ram_wdata = (in_access && gnt_is_d) ? d_wdata : '0;

    assign i_ack   = in_resp && (gnt_q == GNT_I);
    assign d_ack   = in_resp && gnt_is_d;
    assign i_rdata = clr ? '0 : (i_ack ? ram_rdata : i_rdata_q);
    assign d_rdata = clr ? '0 : ((d_ack && !d_we) ? ram_rdata : d_rdata_q);
    assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: a behavioural RAM plus a reference memory for expectations.
module tb_imem_dmem_arbiter;
    localparam byte P_I = 8'h49;
    localparam byte P_D = 8'h44;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        i_req = 1'b0;
    logic [9:0]  i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [9:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        busy;

    imem_dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(2)) dut (
        .clk(clk), .clr(clr),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] tb_ram  [0:1023];
    logic [31:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) tb_ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
            ram_rdata <= tb_ram[ram_addr];
        end
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
    } d_exp_t;

    logic [31:0] i_sb [$];
    d_exp_t      d_sb [$];
    byte         ack_port [$];
    int          ack_cyc [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          d_ack_cnt = 0;
    logic [31:0] last_d_rd = '0;
    logic [31:0] i_e;
    d_exp_t      d_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (i_ack) begin
            ack_port.push_back(P_I);
            ack_cyc.push_back(cyc);
            if (i_sb.size() == 0) begin
                chk("i_unexpected_ack", 32'd1, 32'd0);
            end else begin
                i_e = i_sb.pop_front();
                chk("i_rdata", i_rdata, i_e);
            end
            $display("[%0d] I ack rdata=%h", cyc, i_rdata);
        end
        if (d_ack) begin
            d_ack_cnt++;
            ack_port.push_back(P_D);
            ack_cyc.push_back(cyc);
            if (d_sb.size() == 0) begin
                chk("d_unexpected_ack", 32'd1, 32'd0);
            end else begin
                d_e = d_sb.pop_front();
                if (d_e.is_wr) begin
                    chk("d_rdata_hold", d_rdata, last_d_rd);
                end else begin
                    chk("d_rdata", d_rdata, d_e.data);
                    last_d_rd = d_e.data;
                end
            end
            $display("[%0d] D ack we=%0b rdata=%h", cyc, d_e.is_wr, d_rdata);
        end
    end

    task automatic wait_i_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ack && n < 40);
        if (!i_ack) chk("i_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_d_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 40);
        if (!d_ack) chk("d_ack_timeout", 32'd0, 32'd1);
    endtask

    // All driver tasks start and end one time unit after a rising edge.
    task automatic i_access(input logic [9:0] a);
        i_req  = 1'b1;
        i_addr = a;
        i_sb.push_back(ref_mem[a]);
        wait_i_ack();
        @(posedge clk) #1;
        i_req = 1'b0;
    endtask

    task automatic d_access(input bit we, input logic [9:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        d_exp_t e;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_be    = be;
        e.is_wr = we;
        e.data  = ref_mem[a];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end
        end
        d_sb.push_back(e);
        wait_d_ack();
        @(posedge clk) #1;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        clr   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        last_d_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte exp_order [6];
        int  cnt0;
        for (int k = 0; k < 1024; k++) begin
            tb_ram[k]  = $urandom;
            ref_mem[k] = tb_ram[k];
        end
        tb_ram[4]     = 32'h00500093; ref_mem[4]     = 32'h00500093;
        tb_ram[10'h10] = 32'h11223344; ref_mem[10'h10] = 32'h11223344;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_outs", {26'd0, i_ack, d_ack, busy, ram_en, ram_we, |ram_be}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk) #1;

        // Single fetch latency
        fork
            i_access(10'h004);
            begin
                @(negedge clk);
                chk("fetch_idle_en", {31'd0, ram_en}, 32'd0);
                @(negedge clk);
                chk("fetch_ram_en", {31'd0, ram_en}, 32'd1);
                chk("fetch_ram_addr", {22'd0, ram_addr}, 32'h4);
                @(negedge clk);
                chk("fetch_ack", {31'd0, i_ack}, 32'd1);
                chk("fetch_rdata", i_rdata, 32'h00500093);
            end
        join
        @(negedge clk);
        chk("fetch_busy_after", {31'd0, busy}, 32'd0);
        @(posedge clk) #1;

        // Same port re-requesting: one access per 3 cycles
        ack_cyc.delete();
        ack_port.delete();
        i_access(10'h008);
        i_access(10'h00c);
        chk("reissue_spacing", ack_cyc[1] - ack_cyc[0], 32'd3);

        // Partial write then readback
        cnt0 = d_ack_cnt;
        d_access(1'b1, 10'h010, 32'hDEADBEEF, 4'b0011);
        repeat (3) @(negedge clk);
        chk("wr_ack_pulses", d_ack_cnt - cnt0, 32'd1);
        @(posedge clk) #1;
        d_access(1'b0, 10'h010, 32'd0, 4'b0000);
        chk("rd_0x10", d_rdata, 32'h1122BEEF);

        // Both ports held: alternating handoff
        do_reset();
        ack_cyc.delete();
        ack_port.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) i_access(10'h100 + 10'(k));
            end
            begin
                for (int k = 0; k < 3; k++) d_access(1'b0, 10'h200 + 10'(k), 32'd0, 4'b0000);
            end
        join
        exp_order = '{P_D, P_I, P_D, P_I, P_D, P_I};
        chk("alt_count", ack_port.size(), 32'd6);
        for (int k = 0; k < 6 && k < ack_port.size(); k++) begin
            chk($sformatf("alt_order%0d", k), {24'd0, ack_port[k]}, {24'd0, exp_order[k]});
            if (k > 0) chk($sformatf("alt_spacing%0d", k), ack_cyc[k] - ack_cyc[k-1], 32'd2);
        end

`ifndef IMEM_DMEM_ARB_RR_EN
        // Starvation: fetch withdraws after losing, then retries together with data
        do_reset();
        for (int k = 0; k < 3; k++) begin
            i_req  = 1'b1;
            i_addr = 10'h300 + 10'(k);
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = 10'h340 + 10'(k);
            d_be   = 4'b0000;
            d_e.is_wr = 1'b0;
            d_e.data  = ref_mem[d_addr];
            d_sb.push_back(d_e);
            if (k < 2) begin
                @(posedge clk) #1;
                i_req = 1'b0;
                @(negedge clk);
                chk($sformatf("starve_gnt%0d", k), {22'd0, ram_addr}, {22'd0, d_addr});
                chk($sformatf("starve_cnt%0d", k), {28'd0, dut.starve_cnt_q}, k + 1);
                wait_d_ack();
                @(posedge clk) #1;
                d_req = 1'b0;
            end else begin
                i_sb.push_back(ref_mem[i_addr]);
                @(posedge clk) #1;
                @(negedge clk);
                chk("starve_gnt2_i", {22'd0, ram_addr}, {22'd0, i_addr});
                chk("starve_cnt_clear", {28'd0, dut.starve_cnt_q}, 32'd0);
                wait_i_ack();
                @(posedge clk) #1;
                i_req = 1'b0;
                wait_d_ack();
                @(posedge clk) #1;
                d_req = 1'b0;
            end
        end
`endif

        // clr during the ACCESS cycle of a write
        @(posedge clk) #1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h020;
        d_wdata = 32'hCAFEF00D;
        d_be    = 4'b1111;
        @(posedge clk) #1;
        clr = 1'b1;
        @(negedge clk);
        chk("clr_no_ram_we", {30'd0, ram_en, ram_we}, 32'd0);
        chk("clr_no_ack", {31'd0, d_ack}, 32'd0);
        @(posedge clk) #1;
        clr   = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        last_d_rd = '0;
        @(negedge clk);
        chk("clr_outs", {26'd0, i_ack, d_ack, busy, ram_en, ram_we, |ram_be}, 32'd0);
        chk("clr_i_rdata", i_rdata, 32'd0);
        chk("clr_d_rdata", d_rdata, 32'd0);
        repeat (3) @(negedge clk);
        chk("clr_ram_unchanged", tb_ram[10'h020], ref_mem[10'h020]);
        @(posedge clk) #1;
        d_access(1'b0, 10'h020, 32'd0, 4'b0000);

        repeat (4) @(negedge clk);
        chk("sb_i_empty", i_sb.size(), 32'd0);
        chk("sb_d_empty", d_sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
